// File: rtl/sm_accumulator_pkg.sv
// Shared fixed-point constants and FSM encoding for the batch accumulator.
// Format is sign-magnitude Q21.10: bit 31 sign, [30:10] integer, [9:0] fraction.
package sm_accumulator_pkg;

    localparam int FP_W = 32;
    localparam int FP_SIGN = 31;
    localparam int FP_FRAC = 10;
    localparam logic [FP_W-2:0] FP_MAXMAG = 31'h7FFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sm_accumulator_sumador.sv
// Combinational sign-magnitude adder (Sumador): Z = a + b, ovf on magnitude carry.
// Unlike signs subtract the smaller magnitude from the larger and take its sign.
module Sumador
    import sm_accumulator_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] Z,
    output logic            ovf
);

    logic [FP_W-1:0] ma;
    logic [FP_W-1:0] mb;
    logic [FP_W-1:0] sum;
    logic [FP_W-1:0] dab;
    logic [FP_W-1:0] dba;

    assign ma  = {1'b0, a[FP_SIGN-1:0]};
    assign mb  = {1'b0, b[FP_SIGN-1:0]};
    assign sum = ma + mb;
    assign dab = ma - mb;
    assign dba = mb - ma;

    always_comb begin
        Z   = '0;
        ovf = 1'b0;
        if (a[FP_SIGN] == b[FP_SIGN]) begin
            Z   = {a[FP_SIGN], sum[FP_SIGN-1:0]};
            ovf = sum[FP_SIGN];
        end else if (ma >= mb) begin
            Z = {a[FP_SIGN], dab[FP_SIGN-1:0]};
        end else begin
            Z = {b[FP_SIGN], dba[FP_SIGN-1:0]};
        end
    end

endmodule

// File: rtl/sm_accumulator.sv
// Batch accumulator: sums LEN sign-magnitude operands through Sumador,
// saturating on overflow, and presents one result with a sticky overflow flag.
module sm_accumulator
    import sm_accumulator_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     acc;
    logic [CNT_W-1:0] remaining;
    logic            sticky;
    logic [31:0]     z;
    logic            ovf;
    logic [31:0]     acc_nxt;
    logic            accept;

    Sumador u_sumador (
        .a   (acc),
        .b   (in_data),
        .Z   (z),
        .ovf (ovf)
    );

    assign accept = in_valid && (state == ST_ACC);

    // Saturate toward the operand sign; never store a negative zero.
    always_comb begin
        acc_nxt = z;
        if (ovf) begin
            acc_nxt = {in_data[FP_SIGN], FP_MAXMAG};
        end else if (z[FP_SIGN-1:0] == '0) begin
            acc_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_ACC : ST_HOLD;
                end
            end
            ST_ACC: begin
                if (accept && remaining == CNT_W'(1)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACC);
        out_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
        out_data  = out_valid ? acc : '0;
        out_ovf   = out_valid && sticky;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            remaining <= '0;
            sticky    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                acc       <= '0;
                remaining <= len;
                sticky    <= 1'b0;
            end
        end else if (accept) begin
            acc       <= acc_nxt;
            sticky    <= sticky | ovf;
            remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Scoreboard bench for sm_accumulator: driver queues expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_sm_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_ready;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    sm_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_batch(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = 8'hxx;
    endtask

    // Present an operand and hold it until the edge that accepts it.
    task automatic send(input logic [31:0] d);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !took; i++) begin
            took = in_ready;
            step();
        end
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: operand %h never accepted", d);
        end
    endtask

    task automatic finish_batch(input string name);
        in_valid = 1'b0;
        chk({name, "_latency"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Monitor: every result handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %h ovf %b", out_data, out_ovf);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("sb_data", out_data, e[31:0]);
                chk("sb_ovf", {31'b0, out_ovf}, {31'b0, e[32]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // in_valid while idle must not be consumed
        in_valid = 1'b1;
        in_data  = 32'h0000_7777;
        step();
        in_valid = 1'b0;
        chk("idle_in_valid", {31'b0, busy}, 32'd0);

        exp_q.push_back({1'b0, 32'h0000_0600});
        begin_batch(8'd2);
        chk("acc_busy", {31'b0, busy}, 32'd1);
        send(32'h0000_0200);
        send(32'h0000_0400);
        finish_batch("pos_sum");

        exp_q.push_back({1'b0, 32'h0000_0000});
        begin_batch(8'd2);
        send(32'h0000_0400);
        send(32'h8000_0400);
        finish_batch("cancel_zero");

        exp_q.push_back({1'b1, 32'h7FFF_FBFF});
        begin_batch(8'd3);
        send(32'h5E6D_23E4);
        send(32'h5E6D_23E4);
        send(32'h8000_0400);
        finish_batch("saturate");

        // negative operands with an in_valid gap between them
        exp_q.push_back({1'b0, 32'h8000_0300});
        begin_batch(8'd2);
        send(32'h8000_0200);
        in_valid = 1'b0;
        step();
        step();
        chk("gap_no_result", {31'b0, out_valid}, 32'd0);
        send(32'h8000_0100);
        finish_batch("neg_gap");

        exp_q.push_back({1'b0, 32'h0000_0000});
        begin_batch(8'd0);
        chk("len0_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd3;
            step();
            chk("len0_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("len0_hold_data", out_data, 32'd0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("len0_idle", {31'b0, busy}, 32'd0);

        begin_batch(8'd3);
        send(32'h0000_1234);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);

        exp_q.push_back({1'b0, 32'h0000_0508});
        begin_batch(8'd1);
        send(32'h0000_0508);
        finish_batch("after_rst");

        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
